addsub_serial_seq: RTL and testbench

- Digit-serial add/subtract sequencer. Computes one WIDTH-bit add or subtract over WIDTH/SLICE cycles.
- Reuses a single SLICE-bit add-with-carry slice (ripple FullAdder chain with carry-in). A registered carry links successive digits.
- Subtract is done as I0 + ~I1 + 1: the I1 digit is inverted and the carry register is preset to 1.
- Area-saving alternative to a full-width Sub/Add instance. Sits between a requester (valid/ready in) and a consumer (valid/ready out).

---
 rtl/addsub_serial_seq.sv | 129 ++++++++++++
 tb/tb_addsub_serial_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_seq.sv
// ============================================================================
// Module      : addsub_serial_seq
// Description : Digit-serial add/subtract sequencer. A single SLICE-bit
//               add-with-carry slice is reused over WIDTH/SLICE cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_serial_seq #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT
);

    localparam int c_NUM_DIGITS = WIDTH / SLICE;
    localparam int c_CNT_W      = (c_NUM_DIGITS > 1) ? $clog2(c_NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(c_NUM_DIGITS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic               r_sub;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_cout;
    logic               r_i_ready;
    logic               r_o_valid;

    logic [SLICE-1:0]   w_digit_a;
    logic [SLICE-1:0]   w_digit_b;
    logic [SLICE-1:0]   w_sum;
    logic               w_carry_out;

    assign w_digit_a = r_a[SLICE-1:0];
    assign w_digit_b = r_b[SLICE-1:0] ^ {SLICE{r_sub}};

    // Shared ripple slice; carry-in comes from the digit-linking carry register.
    always_comb begin
        logic w_c;
        w_c   = r_carry;
        w_sum = '0;
        for (int i = 0; i < SLICE; i++) begin
            w_sum[i] = w_digit_a[i] ^ w_digit_b[i] ^ w_c;
            w_c      = (w_digit_a[i] & w_digit_b[i]) | (w_c & (w_digit_a[i] ^ w_digit_b[i]));
        end
        w_carry_out = w_c;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_sub     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cout    <= 1'b0;
            r_i_ready <= 1'b1;
            r_o_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (I_VALID) begin
                        r_a       <= I0;
                        r_b       <= I1;
                        r_sub     <= SUB;
                        r_carry   <= SUB;
                        r_cnt     <= '0;
                        r_res     <= '0;
                        r_cout    <= 1'b0;
                        r_i_ready <= 1'b0;
                        r_state   <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_res[r_cnt*SLICE +: SLICE] <= w_sum;
                    r_carry <= w_carry_out;
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    if (r_cnt == c_LAST_DIGIT) begin
                        r_cout    <= w_carry_out;
                        r_o_valid <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    // Result is held until the consumer takes it.
                    if (O_READY) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_o_valid <= 1'b0;
                    r_i_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign I_READY = r_i_ready;
    assign O_VALID = r_o_valid;
    assign O       = r_res;
    assign COUT    = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_addsub_serial_seq.sv
// ============================================================================
// Module      : tb_addsub_serial_seq
// Description : Self-checking bench for addsub_serial_seq (WIDTH=8, SLICE=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_serial_seq;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       I_VALID = 1'b0;
    logic       I_READY;
    logic [7:0] I0 = '0;
    logic [7:0] I1 = '0;
    logic       SUB = 1'b0;
    logic       O_VALID;
    logic       O_READY = 1'b0;
    logic [7:0] O;
    logic       COUT;

    int n_checks = 0;
    int n_errors = 0;

    addsub_serial_seq #(.WIDTH(8), .SLICE(2)) dut (
        .CLK(CLK), .RESET(RESET), .I_VALID(I_VALID), .I_READY(I_READY),
        .I0(I0), .I1(I1), .SUB(SUB), .O_VALID(O_VALID), .O_READY(O_READY),
        .O(O), .COUT(COUT)
    );

    always #5 CLK = ~CLK;

    // Reference: {COUT, O}. Subtract yields the difference and a no-borrow flag.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int r;
        if (sub) begin
            r = int'(a) - int'(b);
            return {(a >= b), 8'(r)};
        end
        r = int'(a) + int'(b);
        return 9'(r);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one op from IDLE; returns the cycle index (accept cycle = 0) at which O_VALID was seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input bit scramble, output int cyc);
        I0 = a; I1 = b; SUB = sub; I_VALID = 1'b1;
        tick();
        I_VALID = 1'b0;
        cyc = 1;
        while (!O_VALID && cyc < 30) begin
            if (scramble) begin
                I0 = 8'($urandom); I1 = 8'($urandom); SUB = 1'($urandom); I_VALID = 1'b1;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(); tick();
        RESET = 1'b0;
        n_checks++;
        if ({I_READY, O_VALID, O, COUT} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL reset: got rdy=%b vld=%b O=%h C=%b want 1 0 00 0", I_READY, O_VALID, O, COUT);
        end
    endtask

    task automatic test_add_latency();
        int cyc;
        logic [8:0] exp;
        int busy_bad;
        exp = model(8'h5A, 8'h33, 1'b0);
        O_READY = 1'b1;
        I0 = 8'h5A; I1 = 8'h33; SUB = 1'b0; I_VALID = 1'b1;
        tick();
        I_VALID = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (!O_VALID && cyc < 30) begin
            if (I_READY !== 1'b0) busy_bad++;
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc != 5) begin
            n_errors++;
            $display("FAIL add_latency: got %0d cycles want 5", cyc);
        end
        n_checks++;
        if ({COUT, O} !== exp || exp !== 9'h08D) begin
            n_errors++;
            $display("FAIL add_result: got O=%h C=%b want O=8d C=0", O, COUT);
        end
        n_checks++;
        if (busy_bad != 0 || I_READY !== 1'b0) begin
            n_errors++;
            $display("FAIL add_busy: got %0d ready-high RUN cycles, rdy=%b in DONE want 0,0", busy_bad, I_READY);
        end
        tick();
        n_checks++;
        if (I_READY !== 1'b1 || O_VALID !== 1'b0) begin
            n_errors++;
            $display("FAIL add_return_idle: got rdy=%b vld=%b want 1 0", I_READY, O_VALID);
        end
    endtask

    task automatic test_sub_and_carry();
        logic [7:0] a_t [4] = '{8'h10, 8'h00, 8'hFF, 8'h80};
        logic [7:0] b_t [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
        logic       s_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [8:0] w_t [4] = '{9'h10F, 9'h0FF, 9'h100, 9'h100};
        int cyc;
        O_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_op(a_t[k], b_t[k], s_t[k], 1'b0, cyc);
            n_checks++;
            if (!O_VALID || {COUT, O} !== w_t[k] || model(a_t[k], b_t[k], s_t[k]) !== w_t[k]) begin
                n_errors++;
                $display("FAIL sub_carry[%0d]: got vld=%b C=%b O=%h want C=%b O=%h",
                         k, O_VALID, COUT, O, w_t[k][8], w_t[k][7:0]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        logic [8:0] exp;
        exp = model(8'hC7, 8'h5E, 1'b1);
        O_READY = 1'b0;
        run_op(8'hC7, 8'h5E, 1'b1, 1'b1, cyc);
        n_checks++;
        if (!O_VALID || {COUT, O} !== exp) begin
            n_errors++;
            $display("FAIL bp_result: got vld=%b C=%b O=%h want 1 %b %h", O_VALID, COUT, O, exp[8], exp[7:0]);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            I0 = 8'($urandom); I1 = 8'($urandom); I_VALID = 1'b1;
            tick();
            if (!O_VALID || I_READY !== 1'b0 || {COUT, O} !== exp) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        I_VALID = 1'b0;
        O_READY = 1'b1;
        tick();
        n_checks++;
        if (O_VALID !== 1'b0 || I_READY !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", O_VALID, I_READY);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        O_READY = 1'b1;
        I0 = 8'hF3; I1 = 8'h2C; SUB = 1'b1; I_VALID = 1'b1;
        tick();
        I_VALID = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_checks++;
        if ({I_READY, O_VALID, O, COUT} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b O=%h C=%b want 1 0 00 0", I_READY, O_VALID, O, COUT);
        end
        run_op(8'h03, 8'h04, 1'b0, 1'b0, cyc);
        n_checks++;
        if (!O_VALID || cyc != 5 || {COUT, O} !== 9'h007) begin
            n_errors++;
            $display("FAIL reset_recover: got vld=%b cyc=%0d C=%b O=%h want 1 5 0 07", O_VALID, cyc, COUT, O);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_t [3] = '{8'h12, 8'hA0, 8'h7F};
        logic [7:0] b_t [3] = '{8'h34, 8'hB1, 8'h7F};
        logic       s_t [3] = '{1'b0, 1'b1, 1'b0};
        int acc_cyc [3];
        int n_acc, n_res, cyc;
        bit acc;
        O_READY = 1'b1;
        n_acc = 0; n_res = 0; cyc = 0;
        I0 = a_t[0]; I1 = b_t[0]; SUB = s_t[0]; I_VALID = 1'b1;
        for (int k = 0; k < 40 && n_res < 3; k++) begin
            acc = I_READY && I_VALID;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 3) begin
                    I0 = a_t[n_acc]; I1 = b_t[n_acc]; SUB = s_t[n_acc];
                end else begin
                    I_VALID = 1'b0;
                end
            end
            if (O_VALID && n_res < 3) begin
                n_checks++;
                if ({COUT, O} !== model(a_t[n_res], b_t[n_res], s_t[n_res])) begin
                    n_errors++;
                    $display("FAIL b2b_result[%0d]: got C=%b O=%h want %h", n_res, COUT, O,
                             model(a_t[n_res], b_t[n_res], s_t[n_res]));
                end
                n_res++;
            end
        end
        I_VALID = 1'b0;
        n_checks++;
        if (n_acc != 3 || n_res != 3) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d accepts %0d results want 3 3", n_acc, n_res);
        end else begin
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6) begin
                n_errors++;
                $display("FAIL b2b_spacing: got %0d,%0d want 6,6",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic       s;
        logic [8:0] exp;
        int cyc, hold;
        for (int k = 0; k < 25; k++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            exp = model(a, b, s);
            O_READY = 1'b0;
            run_op(a, b, s, 1'b1, cyc);
            I_VALID = 1'b0;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) tick();
            n_checks++;
            if (!O_VALID || cyc != 5 || {COUT, O} !== exp) begin
                n_errors++;
                $display("FAIL random[%0d] %h %s %h: got vld=%b cyc=%0d C=%b O=%h want C=%b O=%h",
                         k, a, s ? "-" : "+", b, O_VALID, cyc, COUT, O, exp[8], exp[7:0]);
            end
            O_READY = 1'b1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub_and_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
